// File: rtl/cfu_seq_pkg.sv
// cfu_seq shared definitions: EFLAGS bits, CMD_* opcodes,
// condition-select encoding and the per-opcode control decode.
package cfu_seq_pkg;

  localparam int FL_CF = 0;
  localparam int FL_PF = 2;
  localparam int FL_ZF = 6;
  localparam int FL_SF = 7;
  localparam int FL_OF = 11;

  localparam logic [6:0] CMD_NOP   = 7'h00;
  // Jcc block 0x10..0x1F: opc[3:1] selects the condition, opc[0] negates it
  localparam logic [6:0] CMD_JO    = 7'h10;
  localparam logic [6:0] CMD_JNO   = 7'h11;
  localparam logic [6:0] CMD_JB    = 7'h12;
  localparam logic [6:0] CMD_JAE   = 7'h13;
  localparam logic [6:0] CMD_JE    = 7'h14;
  localparam logic [6:0] CMD_JNE   = 7'h15;
  localparam logic [6:0] CMD_JBE   = 7'h16;
  localparam logic [6:0] CMD_JA    = 7'h17;
  localparam logic [6:0] CMD_JS    = 7'h18;
  localparam logic [6:0] CMD_JNS   = 7'h19;
  localparam logic [6:0] CMD_JP    = 7'h1A;
  localparam logic [6:0] CMD_JNP   = 7'h1B;
  localparam logic [6:0] CMD_JL    = 7'h1C;
  localparam logic [6:0] CMD_JNL   = 7'h1D;
  localparam logic [6:0] CMD_JLE   = 7'h1E;
  localparam logic [6:0] CMD_JG    = 7'h1F;
  localparam logic [6:0] CMD_JCXZ  = 7'h20;
  localparam logic [6:0] CMD_LOOP  = 7'h21;
  localparam logic [6:0] CMD_JMPR  = 7'h22;
  localparam logic [6:0] CMD_CALLR = 7'h23;
  localparam logic [6:0] CMD_JMPI  = 7'h24;
  localparam logic [6:0] CMD_CALLI = 7'h25;
  localparam logic [6:0] CMD_RET   = 7'h26;

  typedef enum logic [2:0] {
    CC_O  = 3'd0,
    CC_B  = 3'd1,
    CC_E  = 3'd2,
    CC_BE = 3'd3,
    CC_S  = 3'd4,
    CC_P  = 3'd5,
    CC_L  = 3'd6,
    CC_LE = 3'd7
  } cc_e;

  typedef struct packed {
    logic taken;
    logic rel;
    logic push;
    logic pop;
  } ctl_t;

  function automatic logic cc_eval(input cc_e cc,
                                   input logic [31:0] fl);
    logic r;
    unique case (cc)
      CC_O:    r = fl[FL_OF];
      CC_B:    r = fl[FL_CF];
      CC_E:    r = fl[FL_ZF];
      CC_BE:   r = fl[FL_CF] | fl[FL_ZF];
      CC_S:    r = fl[FL_SF];
      CC_P:    r = fl[FL_PF];
      CC_L:    r = fl[FL_SF] ^ fl[FL_OF];
      default: r = fl[FL_ZF] | (fl[FL_SF] ^ fl[FL_OF]);
    endcase
    return r;
  endfunction

  function automatic ctl_t cfu_decode(input logic [6:0]  opc,
                                      input logic [31:0] fl,
                                      input logic        cx_zero,
                                      input logic        cx_one);
    ctl_t d;
    d = '0;
    unique case (1'b1)
      (opc[6:4] == 3'b001): begin
        d.taken = cc_eval(cc_e'(opc[3:1]), fl) ^ opc[0];
        d.rel   = 1'b1;
      end
      (opc == CMD_JCXZ): begin
        d.taken = cx_zero;
        d.rel   = 1'b1;
      end
      (opc == CMD_LOOP): begin
        d.taken = !cx_one;
        d.rel   = 1'b1;
      end
      (opc == CMD_JMPR): begin
        d.taken = 1'b1;
        d.rel   = 1'b1;
      end
      (opc == CMD_CALLR): begin
        d.taken = 1'b1;
        d.rel   = 1'b1;
        d.push  = 1'b1;
      end
      (opc == CMD_JMPI): d.taken = 1'b1;
      (opc == CMD_CALLI): begin
        d.taken = 1'b1;
        d.push  = 1'b1;
      end
      (opc == CMD_RET): begin
        d.taken = 1'b1;
        d.pop   = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cfu_seq_if.sv
// cfu_seq handshake bundle: decode/execute record in,
// resolved next-EIP record out to fetch.
interface cfu_seq_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opc;
  logic [31:0]       eflags;
  logic [ADDR_W-1:0] ecx;
  logic [LEN_W-1:0]  instr_len;
  logic [ADDR_W-1:0] address;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] next_eip;
  logic              taken;

  modport master (
    output in_valid, opc, eflags, ecx,
    output instr_len, address, out_ready,
    input  in_ready, out_valid, next_eip, taken
  );

  modport slave (
    input  in_valid, opc, eflags, ecx,
    input  instr_len, address, out_ready,
    output in_ready, out_valid, next_eip, taken
  );
endinterface

// File: rtl/cfu_seq_return_stack.sv
// Circular shadow return stack: a push when full
// overwrites the oldest entry and leaves count at DEPTH.
module cfu_seq_return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            push_data,
  output logic [W-1:0]            top,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_top_idx;

  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign count     = r_cnt;
  assign full      = (r_cnt == FULL_CNT);
  assign empty     = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!full)
        r_cnt <= r_cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push)
      r_mem[r_ptr] <= push_data;
  end

endmodule

// File: rtl/cfu_seq.sv
// cfu_seq: registered control flow unit owning EIP,
// resolving branch targets and shadowing CALL/RET.
module cfu_seq
  import cfu_seq_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              LEN_W     = 4,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_EIP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  cfu_seq_if.slave          bus,
  output logic [ADDR_W-1:0] eip,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              cf_violation,
  output logic              len_fault
);

  logic [ADDR_W-1:0] r_eip;
  logic [ADDR_W-1:0] r_next;
  logic              r_out_valid;
  logic              r_taken;
  logic              r_ovf;
  logic              r_unf;
  logic              r_cfv;
  logic              r_lenf;

  logic              w_in_ready;
  logic              w_acc;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_next;
  ctl_t              w_ctl;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_top;
  logic [$clog2(RAS_DEPTH):0] w_ras_cnt;
  logic              w_full;
  logic              w_empty;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_acc      = bus.in_valid && w_in_ready;

  assign w_seq = r_eip + ADDR_W'(bus.instr_len);
  assign w_ctl = cfu_decode(bus.opc, bus.eflags,
                            bus.ecx == '0,
                            bus.ecx == ADDR_W'(1));
  assign w_tgt  = w_ctl.rel ? w_seq + bus.address
                            : bus.address;
  assign w_next = w_ctl.taken ? w_tgt : w_seq;

  assign w_push = w_acc && w_ctl.push;
  assign w_pop  = w_acc && w_ctl.pop;

  cfu_seq_return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_seq),
    .top       (w_top),
    .count     (w_ras_cnt),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eip       <= RESET_EIP;
      r_next      <= RESET_EIP;
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
    end else if (w_acc) begin
      r_eip       <= w_next;
      r_next      <= w_next;
      r_out_valid <= 1'b1;
      r_taken     <= w_ctl.taken;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_cfv  <= 1'b0;
      r_lenf <= 1'b0;
    end else if (w_acc) begin
      if (w_push && w_full)
        r_ovf <= 1'b1;
      if (w_pop && w_empty)
        r_unf <= 1'b1;
      if (w_pop && !w_empty && w_top != bus.address)
        r_cfv <= 1'b1;
      if (bus.instr_len == '0)
        r_lenf <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.next_eip  = r_next;
  assign bus.taken     = r_taken;
  assign eip           = r_eip;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
  assign cf_violation  = r_cfv;
  assign len_fault     = r_lenf;

endmodule

// File: tb/tb_cfu_seq.sv
// Directed-vector bench for cfu_seq with hand-computed results.
module tb_cfu_seq;
  import cfu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] eip;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        cf_violation;
  logic        len_fault;
  int          n_vec;
  int          n_bad;

  cfu_seq_if #(.ADDR_W(32), .LEN_W(4)) bus ();

  cfu_seq #(
    .ADDR_W    (32),
    .LEN_W     (4),
    .RAS_DEPTH (2),
    .RESET_EIP (32'h1000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .eip           (eip),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .cf_violation  (cf_violation),
    .len_fault     (len_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, exp %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [6:0]  o,
                      input logic [31:0] fl,
                      input logic [31:0] cx,
                      input logic [3:0]  ln,
                      input logic [31:0] ad);
    bus.opc       = o;
    bus.eflags    = fl;
    bus.ecx       = cx;
    bus.instr_len = ln;
    bus.address   = ad;
  endtask

  task automatic send(input string       tag,
                      input logic [6:0]  o,
                      input logic [31:0] fl,
                      input logic [31:0] cx,
                      input logic [3:0]  ln,
                      input logic [31:0] ad,
                      input logic [31:0] exp_next,
                      input logic        exp_taken);
    load(o, fl, cx, ln, ad);
    bus.in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, ".next_eip"}, bus.next_eip, exp_next);
    chk({tag, ".taken"}, 32'(bus.taken), 32'(exp_taken));
    chk({tag, ".eip"}, eip, exp_next);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic flags(input string tag, input logic [3:0] exp);
    chk({tag, ".flags"},
        32'({ras_overflow, ras_underflow, cf_violation, len_fault}),
        32'(exp));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    load(CMD_NOP, 32'h0, 32'h0, 4'd1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.eip", eip, 32'h1000);
    chk("rst.next_eip", bus.next_eip, 32'h1000);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.taken", 32'(bus.taken), 32'd0);
    flags("rst", 4'b0000);
    rst_n = 1'b1;

    send("nop", CMD_NOP, 32'h0, 32'h0, 4'd3, 32'h0, 32'h1003, 1'b0);
    send("jmpi", CMD_JMPI, 32'h0, 32'h0, 4'd5, 32'h1000, 32'h1000, 1'b1);
    send("je_t", CMD_JE, 32'h40, 32'h0, 4'd2, 32'hFFFF_FFF0,
         32'h0FF2, 1'b1);
    send("jmpi", CMD_JMPI, 32'h0, 32'h0, 4'd5, 32'h1000, 32'h1000, 1'b1);
    send("je_nt", CMD_JE, 32'h0, 32'h0, 4'd2, 32'hFFFF_FFF0,
         32'h1002, 1'b0);
    send("jg_nt", CMD_JG, 32'h80, 32'h0, 4'd2, 32'h40, 32'h1004, 1'b0);
    send("jl_t", CMD_JL, 32'h80, 32'h0, 4'd2, 32'h0, 32'h1006, 1'b1);
    send("loop1", CMD_LOOP, 32'h0, 32'h1, 4'd2, 32'h10, 32'h1008, 1'b0);
    send("loop5", CMD_LOOP, 32'h0, 32'h5, 4'd2, 32'h10, 32'h101A, 1'b1);
    send("jcxz", CMD_JCXZ, 32'h0, 32'h0, 4'd2, 32'h8, 32'h1024, 1'b1);
    send("jbe_t", CMD_JBE, 32'h1, 32'h0, 4'd2, 32'h0, 32'h1026, 1'b1);
    send("ja_nt", CMD_JA, 32'h1, 32'h0, 4'd2, 32'h0, 32'h1028, 1'b0);

    // depth 2: third CALL overwrites 0x102D, the oldest entry
    send("call1", CMD_CALLI, 32'h0, 32'h0, 4'd5, 32'h4000, 32'h4000, 1'b1);
    send("call2", CMD_CALLI, 32'h0, 32'h0, 4'd5, 32'h5000, 32'h5000, 1'b1);
    flags("call2", 4'b0000);
    send("call3", CMD_CALLI, 32'h0, 32'h0, 4'd5, 32'h6000, 32'h6000, 1'b1);
    flags("call3", 4'b1000);
    send("ret1", CMD_RET, 32'h0, 32'h0, 4'd1, 32'h5005, 32'h5005, 1'b1);
    send("ret2", CMD_RET, 32'h0, 32'h0, 4'd1, 32'h4005, 32'h4005, 1'b1);
    flags("ret2", 4'b1000);
    send("ret3", CMD_RET, 32'h0, 32'h0, 4'd1, 32'h102D, 32'h102D, 1'b1);
    flags("ret3", 4'b1100);

    send("jmpi", CMD_JMPI, 32'h0, 32'h0, 4'd5, 32'h2000, 32'h2000, 1'b1);
    send("calli", CMD_CALLI, 32'h0, 32'h0, 4'd5, 32'h3000, 32'h3000, 1'b1);
    send("ret_ok", CMD_RET, 32'h0, 32'h0, 4'd1, 32'h2005, 32'h2005, 1'b1);
    flags("ret_ok", 4'b1100);
    send("jmpi", CMD_JMPI, 32'h0, 32'h0, 4'd5, 32'h2000, 32'h2000, 1'b1);
    send("callr", CMD_CALLR, 32'h0, 32'h0, 4'd5, 32'h1000, 32'h3005, 1'b1);
    send("ret_bad", CMD_RET, 32'h0, 32'h0, 4'd1, 32'h2006, 32'h2006, 1'b1);
    flags("ret_bad", 4'b1110);

    send("len0", CMD_NOP, 32'h0, 32'h0, 4'd0, 32'h0, 32'h2006, 1'b0);
    flags("len0", 4'b1111);
    send("unk", 7'h7F, 32'hFFFF_FFFF, 32'h0, 4'd1, 32'h9000,
         32'h2007, 1'b0);
    send("jmpi", CMD_JMPI, 32'h0, 32'h0, 4'd5, 32'hFFFF_FFFE,
         32'hFFFF_FFFE, 1'b1);
    send("wrap", CMD_NOP, 32'h0, 32'h0, 4'd4, 32'h0, 32'h0000_0002, 1'b0);

    @(posedge clk);
    #1;
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    load(CMD_NOP, 32'h0, 32'h0, 4'd1, 32'h0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("hold0.next_eip", bus.next_eip, 32'h3);
    load(CMD_JMPI, 32'h0, 32'h0, 4'd5, 32'h8000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold.next_eip", bus.next_eip, 32'h3);
      chk("hold.taken", 32'(bus.taken), 32'd0);
      chk("hold.eip", eip, 32'h3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.eip", eip, 32'h1000);
    chk("midrst.next_eip", bus.next_eip, 32'h1000);
    flags("midrst", 4'b0000);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    send("post", CMD_NOP, 32'h0, 32'h0, 4'd3, 32'h0, 32'h1003, 1'b0);
    send("post_ret", CMD_RET, 32'h0, 32'h0, 4'd1, 32'h1234, 32'h1234, 1'b1);
    flags("post_ret", 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
